fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit pipelined CPU.
- Owns the PC, drives the instruction-memory request and accepts variable-latency responses.
- Presents instrD to the decode stage; instrD[15:14], [13:11], [10:8] and [7:4] feed the decoder's op1, op2, cond and op3 fields.
- Resolves next-PC among branch redirect, jump, stall and sequential fetch, and runs the halt state machine.

Parameters:
- WIDTH, 16, instruction and PC width (word-addressed; sequential step +1).
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'hB800, bubble encoding written into instrD on flush/squash; the decoder produces no register or memory write for it.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stallF  in  1  hazard unit: hold PC, no new request.
- stallD  in  1  hazard unit: hold IF/ID register.
- flushD  in  1  hazard unit: force bubble into IF/ID.
- pcsrcE  in  1  taken branch resolved in EX.
- pcbranchE  in  WIDTH  branch target.
- jumpD  in  1  decoder jump for the instruction in D.
- pcjumpD  in  WIDTH  jump target.
- haltD  in  1  decoder halt for the instruction in D.
- imem_req  out  1  fetch request.
- imem_addr  out  WIDTH  fetch address (= pcF).
- imem_valid  in  1  response valid; rdata valid the same cycle.
- imem_rdata  in  WIDTH  instruction word.
- instrD  out  WIDTH  IF/ID instruction.
- pcplus1D  out  WIDTH  IF/ID PC+1.
- validD  out  1  IF/ID holds a real instruction.
- haltedF  out  1  core halted.
- fetch_cnt  out  16  accepted-fetch counter.

Behaviour:
- Reset: pcF=RESET_PC; instrD=NOP_INSTR; pcplus1D=0; validD=0; haltedF=0; fetch_cnt=0; state=RUN.
- States: RUN and HALTED.
  - RUN -> HALTED when haltD & validD & ~flushD & ~pcsrcE & ~stallD.
  - HALTED exits only via reset.
- Request: imem_req = (state==RUN) & ~stallF. imem_addr = pcF, combinational.
- The memory is combinational-ready: a fetch is accepted in a cycle when imem_req & imem_valid. No outstanding requests exist across cycles, so a redirect never sees a stale response.
- Taken jump: jtaken = jumpD & validD & ~stallD & ~flushD.
- Next PC, highest priority first:
  1. reset -> RESET_PC
  2. HALTED -> hold
  3. pcsrcE -> pcbranchE
  4. stallF -> hold
  5. jtaken -> pcjumpD
  6. accept -> pcF+1, modulo 2^WIDTH (0xFFFF wraps to 0x0000)
  7. otherwise hold (memory wait)
- IF/ID register, highest priority first:
  1. reset -> reset values
  2. flushD | pcsrcE | jtaken -> bubble (instrD=NOP_INSTR, validD=0, pcplus1D unchanged)
  3. stallD -> hold all fields
  4. accept -> instrD=imem_rdata, pcplus1D=pcF+1, validD=1
  5. otherwise -> bubble
- HALTED: no requests; IF/ID takes bubbles unless stallD; haltedF=1 from the cycle after the transition.
- fetch_cnt increments by 1 on each accept; wraps at 16 bits; cleared only by reset.
- Simultaneous pcsrcE and haltD: branch wins; the halt is squashed and the state stays RUN.
- Simultaneous pcsrcE and accept: PC takes pcbranchE, the fetched word is discarded as a bubble, and fetch_cnt still increments.
- stallF & ~stallD: D receives a bubble.
- stallD & ~stallF is illegal (the hazard unit never issues it); assert in simulation.
- Reset mid-wait or mid-halt returns to RUN with PC=RESET_PC the next cycle.

Test Plan:
- Release reset, imem_valid=1, memory[i]=0x1000+i -> imem_addr 0,1,2,...; instrD=0x1000,0x1001 one cycle behind; validD=1 from the 2nd cycle; pcplus1D=1,2.
- imem_valid low for 3 cycles at pc=5 -> imem_addr held at 5; 3 bubbles (validD=0, instrD=NOP_INSTR); then instrD=mem[5], pcplus1D=6.
- jumpD=1, pcjumpD=0x0040 with validD=1 -> next imem_addr=0x0040; the word fetched in the jump cycle becomes a bubble.
- Cycle with pcsrcE=1, pcbranchE=0x0100, haltD=1 -> PC=0x0100; haltedF stays 0; fetching continues.
- haltD=1 with validD=1 and no stall/flush -> haltedF=1 next cycle; imem_req=0; PC and fetch_cnt frozen. Then reset=1 for 1 cycle -> PC=0, haltedF=0, fetching resumes.
- stallF=stallD=1 for 2 cycles at pc=0x0007 -> imem_req=0, PC holds, instrD holds. PC=0xFFFF with an accept -> PC wraps to 0x0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC, halt FSM and IF/ID pipeline register.
// Single-cycle memory handshake: a fetch is accepted when imem_req & imem_valid.
module fetch_stage #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_PC  = 16'h0000,
  parameter logic [WIDTH-1:0] NOP_INSTR = 16'hB800
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallF,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             pcsrcE,
  input  logic [WIDTH-1:0] pcbranchE,
  input  logic             jumpD,
  input  logic [WIDTH-1:0] pcjumpD,
  input  logic             haltD,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_valid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instrD,
  output logic [WIDTH-1:0] pcplus1D,
  output logic             validD,
  output logic             haltedF,
  output logic [15:0]      fetch_cnt
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pcF, pc_next, pcplus1F;
  logic [WIDTH-1:0] instr_next, pcplus1_next;
  logic             valid_next;
  logic             accept, jtaken;

  assign pcplus1F  = pcF + 1'b1;
  assign imem_req  = (state == RUN) && !stallF;
  assign imem_addr = pcF;
  assign accept    = imem_req && imem_valid;
  assign jtaken    = jumpD && validD && !stallD && !flushD;
  assign haltedF   = (state == HALTED);

  always_comb begin
    state_next = state;
    if (state == RUN && haltD && validD && !flushD && !pcsrcE && !stallD)
      state_next = HALTED;
  end

  always_comb begin
    pc_next = pcF;
    if (state == HALTED)  pc_next = pcF;
    else if (pcsrcE)      pc_next = pcbranchE;
    else if (stallF)      pc_next = pcF;
    else if (jtaken)      pc_next = pcjumpD;
    else if (accept)      pc_next = pcplus1F;
  end

  // Redirects squash whatever was fetched this cycle; pcplus1D is left as-is on a bubble.
  always_comb begin
    instr_next   = NOP_INSTR;
    pcplus1_next = pcplus1D;
    valid_next   = 1'b0;
    if (flushD || pcsrcE || jtaken) begin
      instr_next = NOP_INSTR;
      valid_next = 1'b0;
    end else if (stallD) begin
      instr_next = instrD;
      valid_next = validD;
    end else if (accept) begin
      instr_next   = imem_rdata;
      pcplus1_next = pcplus1F;
      valid_next   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pcF       <= RESET_PC;
      instrD    <= NOP_INSTR;
      pcplus1D  <= '0;
      validD    <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state     <= state_next;
      pcF       <= pc_next;
      instrD    <= instr_next;
      pcplus1D  <= pcplus1_next;
      validD    <= valid_next;
      if (accept) fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(stallD && !stallF));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns 0x1000 + address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stallF, stallD, flushD, pcsrcE, jumpD, haltD, imem_valid;
  logic [15:0] pcbranchE, pcjumpD, imem_rdata;
  logic        imem_req, validD, haltedF;
  logic [15:0] imem_addr, instrD, pcplus1D, fetch_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = 16'h1000 + imem_addr;

  fetch_stage #(.WIDTH(16), .RESET_PC(16'h0000), .NOP_INSTR(16'hB800)) dut (
    .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .pcsrcE(pcsrcE), .pcbranchE(pcbranchE), .jumpD(jumpD), .pcjumpD(pcjumpD),
    .haltD(haltD), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instrD(instrD),
    .pcplus1D(pcplus1D), .validD(validD), .haltedF(haltedF), .fetch_cnt(fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [15:0] pc, input logic [15:0] ins,
                              input logic [15:0] pp1, input logic vld, input logic [15:0] cnt);
    check({tag, ".pc"},    imem_addr, pc);
    check({tag, ".instr"}, instrD,    ins);
    check({tag, ".pp1"},   pcplus1D,  pp1);
    check({tag, ".valid"}, validD,    vld);
    check({tag, ".cnt"},   fetch_cnt, cnt);
  endtask

  initial begin
    reset = 1; stallF = 0; stallD = 0; flushD = 0; pcsrcE = 0; jumpD = 0; haltD = 0;
    imem_valid = 1; pcbranchE = '0; pcjumpD = '0;
    tick(); tick();
    expect_state("reset", 16'h0000, 16'hB800, 16'h0000, 0, 16'd0);
    check("reset.halted", haltedF, 0);

    reset = 0; #1;
    check("run.req", imem_req, 1);
    tick(); expect_state("seq1", 16'h0001, 16'h1000, 16'h0001, 1, 16'd1);
    tick(); expect_state("seq2", 16'h0002, 16'h1001, 16'h0002, 1, 16'd2);
    tick(); tick(); tick();
    expect_state("seq5", 16'h0005, 16'h1004, 16'h0005, 1, 16'd5);

    imem_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_state("wait", 16'h0005, 16'hB800, 16'h0005, 0, 16'd5);
    end
    imem_valid = 1;
    tick(); expect_state("resume", 16'h0006, 16'h1005, 16'h0006, 1, 16'd6);

    jumpD = 1; pcjumpD = 16'h0040;
    tick(); expect_state("jump", 16'h0040, 16'hB800, 16'h0006, 0, 16'd7);
    jumpD = 0;
    tick(); expect_state("jump_tgt", 16'h0041, 16'h1040, 16'h0041, 1, 16'd8);

    pcsrcE = 1; pcbranchE = 16'h0100; haltD = 1;
    tick(); expect_state("br_halt", 16'h0100, 16'hB800, 16'h0041, 0, 16'd9);
    check("br_halt.halted", haltedF, 0);
    pcsrcE = 0; haltD = 0;
    tick(); expect_state("br_tgt", 16'h0101, 16'h1100, 16'h0101, 1, 16'd10);
    check("br_tgt.halted", haltedF, 0);

    stallF = 1; stallD = 1; #1;
    check("stall.req", imem_req, 0);
    tick(); tick();
    expect_state("stall", 16'h0101, 16'h1100, 16'h0101, 1, 16'd10);
    stallF = 0; stallD = 0;
    tick(); expect_state("unstall", 16'h0102, 16'h1101, 16'h0102, 1, 16'd11);

    haltD = 1;
    tick(); expect_state("halt_edge", 16'h0103, 16'h1102, 16'h0103, 1, 16'd12);
    check("halt.halted", haltedF, 1);
    check("halt.req", imem_req, 0);
    haltD = 0;
    tick(); tick();
    expect_state("halted", 16'h0103, 16'hB800, 16'h0103, 0, 16'd12);
    check("halted.halted", haltedF, 1);

    reset = 1;
    tick();
    reset = 0; #1;
    expect_state("rst2", 16'h0000, 16'hB800, 16'h0000, 0, 16'd0);
    check("rst2.halted", haltedF, 0);
    check("rst2.req", imem_req, 1);
    tick(); expect_state("rst2_run", 16'h0001, 16'h1000, 16'h0001, 1, 16'd1);

    pcsrcE = 1; pcbranchE = 16'hFFFF;
    tick(); expect_state("br_top", 16'hFFFF, 16'hB800, 16'h0001, 0, 16'd2);
    pcsrcE = 0;
    tick(); expect_state("wrap", 16'h0000, 16'h0FFF, 16'h0000, 1, 16'd3);

    flushD = 1;
    tick(); expect_state("flush", 16'h0001, 16'hB800, 16'h0000, 0, 16'd4);
    flushD = 0; stallF = 1;
    tick(); expect_state("stallF_only", 16'h0001, 16'hB800, 16'h0000, 0, 16'd4);
    stallF = 0;
    tick(); expect_state("after", 16'h0002, 16'h1001, 16'h0002, 1, 16'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
